// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_if
// Brief    : Requester/consumer bundle for the two-way round-robin mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid_a;
  logic [WIDTH-1:0] req_data_a;
  logic             req_ready_a;
  logic             req_valid_b;
  logic [WIDTH-1:0] req_data_b;
  logic             req_ready_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             gnt_a;
  logic             gnt_b;

  // Arbiter side
  modport master (
    input  req_valid_a, req_data_a, req_valid_b, req_data_b, out_ready,
    output req_ready_a, req_ready_b, out_valid, out_data, out_src, gnt_a, gnt_b
  );

  // Producer/consumer side
  modport slave (
    output req_valid_a, req_data_a, req_valid_b, req_data_b, out_ready,
    input  req_ready_a, req_ready_b, out_valid, out_data, out_src, gnt_a, gnt_b
  );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter
// Brief    : Two-requester burst round-robin arbiter steering a shared data mux
//            into a single-entry output register. Define ARB_FIXED_PRIO_EN for
//            fixed priority to A (A unlimited, B still burst-limited).
// Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mux_arbiter_if.master bus
);

  localparam int               CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       S_IDLE     = 2'd0;
  localparam logic [1:0]       S_OWN_A    = 2'd1;
  localparam logic [1:0]       S_OWN_B    = 2'd2;
  localparam logic             C_SRC_A    = 1'b1;
  localparam logic             C_SRC_B    = 1'b0;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             w_space;
  logic             w_xfer_a;
  logic             w_xfer_b;
  logic             w_a_limited;
  logic             w_tie_to_a;

`ifdef ARB_FIXED_PRIO_EN
  assign w_a_limited = 1'b0;
  assign w_tie_to_a  = 1'b1;
`else
  assign w_a_limited = 1'b1;
  assign w_tie_to_a  = (r_last == C_SRC_B);
`endif

  assign w_space  = !r_out_valid | bus.out_ready;
  assign w_xfer_a = (r_state == S_OWN_A) & bus.req_valid_a & w_space;
  assign w_xfer_b = (r_state == S_OWN_B) & bus.req_valid_b & w_space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= C_SRC_B;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.req_valid_a && (!bus.req_valid_b || w_tie_to_a)) begin
          w_state_nxt = S_OWN_A;
          w_last_nxt  = C_SRC_A;
        end else if (bus.req_valid_b) begin
          w_state_nxt = S_OWN_B;
          w_last_nxt  = C_SRC_B;
        end
      end
      S_OWN_A: begin
        if (!bus.req_valid_a) begin
          w_cnt_nxt = '0;
          if (bus.req_valid_b) begin
            w_state_nxt = S_OWN_B;
            w_last_nxt  = C_SRC_B;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_space && w_a_limited) begin
          if (r_cnt != C_CNT_LAST) begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end else begin
            // Burst exhausted: hand over only if B is actually waiting
            w_cnt_nxt = '0;
            if (bus.req_valid_b) begin
              w_state_nxt = S_OWN_B;
              w_last_nxt  = C_SRC_B;
            end
          end
        end
      end
      S_OWN_B: begin
        if (!bus.req_valid_b) begin
          w_cnt_nxt = '0;
          if (bus.req_valid_a) begin
            w_state_nxt = S_OWN_A;
            w_last_nxt  = C_SRC_A;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_space) begin
          if (r_cnt != C_CNT_LAST) begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end else begin
            w_cnt_nxt = '0;
            if (bus.req_valid_a) begin
              w_state_nxt = S_OWN_A;
              w_last_nxt  = C_SRC_A;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A load takes precedence over a drain so a word can be replaced in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_xfer_a) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.req_data_a;
      r_out_src   <= C_SRC_A;
    end else if (w_xfer_b) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.req_data_b;
      r_out_src   <= C_SRC_B;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.req_ready_a = (r_state == S_OWN_A) & w_space;
    bus.req_ready_b = (r_state == S_OWN_B) & w_space;
    bus.gnt_a       = (r_state == S_OWN_A);
    bus.gnt_b       = (r_state == S_OWN_B);
    bus.out_valid   = r_out_valid;
    bus.out_data    = r_out_data;
    bus.out_src     = r_out_src;
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Directed table bench for mux_arbiter plus ordering scoreboard under random backpressure.
module tb_mux_arbiter;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_arbiter #(.WIDTH(WIDTH), .BURST_LEN(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // flags = {ready_a, ready_b, out_valid, out_src, gnt_a, gnt_b}
  typedef struct {
    bit          rstn;
    bit          va;
    logic [31:0] da;
    bit          vb;
    logic [31:0] db;
    bit          ordy;
    bit [5:0]    flags;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic v(input bit rstn, input bit va, input logic [31:0] da, input bit vb,
                   input logic [31:0] db, input bit ordy, input bit [5:0] fl, input logic [31:0] od);
    vec_t t;
    t.rstn = rstn; t.va = va; t.da = da; t.vb = vb; t.db = db;
    t.ordy = ordy; t.flags = fl; t.od = od;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] act_flags();
    return {bus.req_ready_a, bus.req_ready_b, bus.out_valid, bus.out_src, bus.gnt_a, bus.gnt_b};
  endfunction

  task automatic drive(input bit va, input logic [31:0] da, input bit vb,
                       input logic [31:0] db, input bit ordy);
    bus.req_valid_a = va; bus.req_data_a = da;
    bus.req_valid_b = vb; bus.req_data_b = db;
    bus.out_ready   = ordy;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    // reset, then A alone sends 0x11, 0x22, 0x33
    v(0, 0, 0,     0, 0, 1, 6'b000000, 0);
    v(1, 0, 0,     0, 0, 1, 6'b000000, 0);
    v(1, 1, 'h11,  0, 0, 1, 6'b000000, 0);
    v(1, 1, 'h11,  0, 0, 1, 6'b100010, 0);
    v(1, 1, 'h22,  0, 0, 1, 6'b101110, 'h11);
    v(1, 1, 'h33,  0, 0, 1, 6'b101110, 'h22);
    v(1, 0, 0,     0, 0, 1, 6'b101110, 'h33);
    v(1, 0, 0,     0, 0, 1, 6'b000100, 'h33);
    // reset, both stream: 4xA then 4xB then A, no bubble
    v(0, 0, 0,     0, 0,     1, 6'b000000, 0);
    v(1, 1, 'hA0,  1, 'hB0,  1, 6'b000000, 0);
    v(1, 1, 'hA1,  1, 'hB1,  1, 6'b100010, 0);
    v(1, 1, 'hA2,  1, 'hB2,  1, 6'b101110, 'hA1);
    v(1, 1, 'hA3,  1, 'hB3,  1, 6'b101110, 'hA2);
    v(1, 1, 'hA4,  1, 'hB4,  1, 6'b101110, 'hA3);
    v(1, 1, 'hA5,  1, 'hB5,  1, 6'b011101, 'hA4);
    v(1, 1, 'hA6,  1, 'hB6,  1, 6'b011001, 'hB5);
    v(1, 1, 'hA7,  1, 'hB7,  1, 6'b011001, 'hB6);
    v(1, 1, 'hA8,  1, 'hB8,  1, 6'b011001, 'hB7);
    v(1, 1, 'hA9,  1, 'hB9,  1, 6'b101010, 'hB8);
    v(1, 0, 0,     0, 0,     1, 6'b101110, 'hA9);
    v(1, 0, 0,     0, 0,     1, 6'b000100, 'hA9);
    // reset, A streams with out_ready low for 5 cycles mid-burst
    v(0, 0, 0,     0, 0, 1, 6'b000000, 0);
    v(1, 1, 'hC0,  0, 0, 1, 6'b000000, 0);
    v(1, 1, 'hC1,  0, 0, 1, 6'b100010, 0);
    for (int i = 0; i < 5; i++) v(1, 1, 'hC2, 0, 0, 0, 6'b001110, 'hC1);
    v(1, 1, 'hC2,  0, 0, 1, 6'b101110, 'hC1);
    v(1, 1, 'hC3,  0, 0, 1, 6'b101110, 'hC2);
    v(1, 0, 0,     0, 0, 1, 6'b101110, 'hC3);
    // A drops after 2 words while B waits; B gets a full burst of 4
    v(1, 1, 'hD0,  0, 0,     1, 6'b000100, 'hC3);
    v(1, 1, 'hD1,  1, 'hE1,  1, 6'b100110, 'hC3);
    v(1, 1, 'hD2,  1, 'hE2,  1, 6'b101110, 'hD1);
    v(1, 0, 0,     1, 'hE3,  1, 6'b101110, 'hD2);
    v(1, 0, 0,     1, 'hE4,  1, 6'b010101, 'hD2);
    v(1, 1, 'hD5,  1, 'hE5,  1, 6'b011001, 'hE4);
    v(1, 1, 'hD6,  1, 'hE6,  1, 6'b011001, 'hE5);
    v(1, 1, 'hD7,  1, 'hE7,  1, 6'b011001, 'hE6);
    v(1, 0, 0,     0, 0,     1, 6'b101010, 'hE7);
    v(1, 0, 0,     0, 0,     1, 6'b000000, 'hE7);
    // asynchronous reset while owning B with a word held, then tie goes to A
    v(1, 0, 0,     1, 'hF0,  1, 6'b000000, 'hE7);
    v(1, 0, 0,     1, 'hF1,  1, 6'b010001, 'hE7);
    v(0, 0, 0,     1, 'hF2,  1, 6'b000000, 0);
    v(1, 1, 'h60,  1, 'h70,  1, 6'b000000, 0);
    v(1, 1, 'h61,  1, 'h71,  1, 6'b100010, 0);
    v(1, 0, 0,     0, 0,     1, 6'b101110, 'h61);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rstn;
      drive(vecs[i].va, vecs[i].da, vecs[i].vb, vecs[i].db, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d flags", i), {26'd0, act_flags()}, {26'd0, vecs[i].flags});
      check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].od);
    end
  endtask

  // Both requesters push 8 numbered words each; every delivered word must be
  // the oldest outstanding one from its source.
  task automatic run_scoreboard();
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_w;
    int sent_a = 0;
    int sent_b = 0;
    int got    = 0;
    pulse_reset();
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      drive(sent_a < 8, 32'hA00 + sent_a, sent_b < 8, 32'hB00 + sent_b, 1'($urandom_range(0, 1)));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_src) begin
          exp_w = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD;
        end else begin
          exp_w = (qb.size() > 0) ? qb.pop_front() : 32'hDEAD;
        end
        check($sformatf("sb word %0d", got), bus.out_data, exp_w);
        got++;
      end
      if (bus.req_valid_a && bus.req_ready_a) begin
        qa.push_back(bus.req_data_a);
        sent_a++;
      end
      if (bus.req_valid_b && bus.req_ready_b) begin
        qb.push_back(bus.req_data_b);
        sent_b++;
      end
    end
    check("sb delivered", got, 16);
    check("sb leftover", qa.size() + qb.size(), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic run_fixed_prio();
    int  nb = 0;
    bit  regained = 1'b0;
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1, 32'h100 + i, 1, 32'h200 + i, 1);
      #1;
      check($sformatf("fixed gnt cyc%0d", i), {30'd0, bus.gnt_a, bus.gnt_b},
            (i == 0) ? 32'd0 : 32'd2);
    end
    @(negedge clk);
    drive(0, 0, 1, 32'h300, 1);
    for (int i = 0; i < 20 && !regained; i++) begin
      @(negedge clk);
      drive(1, 32'h400 + i, 1, 32'h300 + i, 1);
      #1;
      if (bus.gnt_a) regained = 1'b1;
      else if (bus.gnt_b && bus.req_ready_b) nb++;
    end
    check("fixed A regains", {31'd0, regained}, 32'd1);
    check("fixed B burst", nb, 4);
  endtask
`endif

  initial begin
    drive(0, 0, 0, 0, 1);
`ifndef ARB_FIXED_PRIO_EN
    run_table();
`else
    run_fixed_prio();
`endif
    run_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mux_arbiter.md
# mux_arbiter

- Two-requester, round-robin arbiter that shares one 32-bit datapath mux between requesters A and B.
- Each requester presents words on a valid/ready handshake. The arbiter grants ownership in bursts, steers the winner through the select (sel=1 picks A, sel=0 picks B), and registers the result into a single-entry output stage.
- It sits between the two producers and the downstream consumer in the core datapath.

## Interface
Parameters:
- WIDTH, 32, data width of every data port.
- BURST_LEN, 4, maximum consecutive transfers per grant while the other side waits; legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_a  in  1  requester A has a word.
- req_data_a  in  WIDTH  requester A word.
- req_ready_a  out  1  A word accepted this cycle when high with req_valid_a.
- req_valid_b  in  1  requester B has a word.
- req_data_b  in  WIDTH  requester B word.
- req_ready_b  out  1  B word accepted this cycle when high with req_valid_b.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered word.
- out_src  out  1  source of out_data: 1 = A, 0 = B.
- out_ready  in  1  consumer takes out_data this cycle when out_valid.
- gnt_a  out  1  state is OWN_A (registered).
- gnt_b  out  1  state is OWN_B (registered).

## Operation
- Definitions:
  - space = !out_valid | out_ready.
  - xfer_x = (state==OWN_x) & req_valid_x & space.
- Ready signals: req_ready_a = (state==OWN_A) & space; req_ready_b likewise for OWN_B.
  - Ready is combinational from state and out_ready.
  - Ready is independent of req_valid.
- State machine states: IDLE, OWN_A, OWN_B. Internal registers are last (last owner) and cnt (0..BURST_LEN-1).
- IDLE:
  - Only A valid → OWN_A.
  - Only B valid → OWN_B.
  - Both valid → the side opposite to last.
  - No ready is asserted in IDLE.
  - On entering OWN_x: last ← x, cnt ← 0.
- OWN_x, when xfer_x occurs:
  - If cnt+1 < BURST_LEN: cnt ← cnt+1 and stay in OWN_x.
  - Otherwise cnt ← 0. If the other side is valid in the same cycle, go to OWN_other (last ← other); else stay in OWN_x.
- OWN_x, when req_valid_x is low: go to OWN_other if the other side is valid, else IDLE; cnt ← 0.
- OWN_x, when req_valid_x is high but space is low: hold state and cnt.
- Output register:
  - On xfer_x: out_data ← req_data_x, out_src ← (x==A), out_valid ← 1.
  - Else if out_ready: out_valid ← 0.
  - out_data and out_src hold when not loaded.
- Simultaneous drain and load (out_valid & out_ready & xfer): the new word replaces the old one and out_valid stays 1.
- Reset values:
  - state=IDLE, last=B (so A wins the first tie), cnt=0.
  - out_valid=0, out_data=0, out_src=0, gnt_a=0, gnt_b=0.
  - req_ready_a=0, req_ready_b=0.
- Reset asserted mid-operation clears everything immediately, asynchronously. The word held in the output register is discarded. Requesters must re-present their words.

## Timing
- Arbitration costs one cycle from IDLE: valid is seen in cycle n, the grant is visible in n+1, and the earliest transfer happens in n+1.
- Transfer-to-output latency is 1 cycle: a word accepted at edge k appears on out_data after edge k.
- Sustained throughput is one word per cycle while out_ready=1, including across an OWN_A↔OWN_B switch. The handover costs no bubble because the next owner is granted at the same edge.
- A falling req_valid of the owner costs one cycle only if the other side is idle (the arbiter returns to IDLE).
- out_ready low for N cycles stalls both requesters for N cycles. No word is lost or duplicated.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Ties in IDLE always go to A, regardless of last.
  - The burst limit does not apply to A: A keeps ownership while req_valid_a is high.
  - B still yields after BURST_LEN transfers if A is valid.
- Not defined: round-robin fairness with the burst limit applied symmetrically, exactly as in Operation.

## Test plan
- Reset, then A sends 3 words (0x11,0x22,0x33) with out_ready=1 → gnt_a one cycle after valid; out_data 0x11,0x22,0x33 on consecutive cycles with out_src=1; then IDLE.
- A and B both stream continuously, BURST_LEN=4, out_ready=1 → output pattern is 4×A, 4×B, 4×A… with no bubble at handovers. The first burst is A.
- Owner A streaming, out_ready held 0 for 5 cycles mid-burst → out_valid stays 1, out_data is frozen, both readies are 0. On release, the words resume in order with none dropped.
- A drops valid after 2 words while B is valid → the next edge enters OWN_B and cnt restarts at 0. B gets the full 4-word burst.
- rst_n pulsed low while out_valid=1 and in OWN_B → out_valid=0 and gnt_b=0 immediately without waiting for a clock edge. After release, the first tie goes to A.
- With ARB_FIXED_PRIO_EN, A and B streaming → A owns indefinitely and B receives nothing. When A stops, B gets at most 4 words before A regains ownership.
